// File: rtl/process_tick_scheduler_pkg.sv
// Shared definitions for the process tick scheduler: default sizes and FSM state encoding.
// CNT_W covers a 320x240 frame, matching the frame buffer controller.
package process_tick_scheduler_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/process_tick_scheduler_if.sv
// Request/grant/tick bundle between top-level control (master) and the scheduler (slave).
interface process_tick_scheduler_if
  import process_tick_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [DIV_W-1:0]       cfg_div;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic [N_REQ-1:0]       grant;
  logic                   tick;
  logic [CNT_W-1:0]       O_ADDR;
  logic [N_REQ-1:0]       done;
  logic                   busy;

  modport master (
    output cfg_div, req, req_len,
    input  grant, tick, O_ADDR, done, busy
  );

  modport slave (
    input  cfg_div, req, req_len,
    output grant, tick, O_ADDR, done, busy
  );

endinterface

// File: rtl/process_tick_scheduler_tick_gen.sv
// Clearable divider: registered tick output that is high in the cycle the count equals div.
// clr/en describe the coming cycle, so tick lines up with the first RUN cycle without delay.
module process_tick_gen
  import process_tick_scheduler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == div) ? '0 : cnt_q + DIV_W'(1);
    end
    tick_d = en && (cnt_d == div);
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/process_tick_scheduler.sv
// Round-robin owner of the divided processing enable; issues per-pixel tick strobes for one job.
// All outputs are flops driven from next-state values, so nothing is combinational from req.
module process_tick_scheduler
  import process_tick_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     I_CLK,
  input  logic                     rst,
  process_tick_scheduler_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick_w;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    return IDX_W'((int'(w) + 1) % N_REQ);
  endfunction

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    div_d   = div_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (|bus.req) begin
          win_d   = rr_pick(bus.req, ptr_q);
          len_d   = bus.req_len[int'(win_d)*CNT_W +: CNT_W];
          div_d   = bus.cfg_div;
          state_d = (len_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Losing the request abandons the job quietly; the pointer still moves past it.
        if (!bus.req[win_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_ptr(win_q);
          addr_d  = '0;
        end else if (tick_w) begin
          if (addr_q == len_q - CNT_W'(1)) begin
            state_d = ST_DONE;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = next_ptr(win_q);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    grant_d = (state_d == ST_IDLE) ? '0 : (N_REQ'(1) << win_d);
    done_d  = (state_d == ST_DONE) ? (N_REQ'(1) << win_d) : '0;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      div_q   <= div_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // The divider restarts on every RUN entry and uses the ratio being latched this edge.
  process_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .I_CLK (I_CLK),
    .rst   (rst),
    .clr   (state_q != ST_RUN),
    .en    (state_d == ST_RUN),
    .div   (div_d),
    .tick  (tick_w)
  );

  assign bus.grant  = grant_q;
  assign bus.tick   = tick_w;
  assign bus.O_ADDR = addr_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_process_tick_scheduler.sv
// Scoreboard bench for process_tick_scheduler: expected ticks/dones are queued when a job
// is started and retired by a negedge monitor as the scheduler produces them.
module tb_process_tick_scheduler;
  import process_tick_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 17;

  typedef struct {
    logic [N-1:0]  grant;
    logic [CW-1:0] addr;
    int            gap;
  } tick_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ref_cyc = 0;

  logic [N-1:0] prev_grant = '0;
  tick_exp_t    exp_ticks[$];
  logic [N-1:0] exp_dones[$];
  tick_exp_t    mon_e;
  logic [N-1:0] mon_d;

  process_tick_scheduler_if #(.N_REQ(N), .DIV_W(DW), .CNT_W(CW)) bus ();

  process_tick_scheduler #(.N_REQ(N), .DIV_W(DW), .CNT_W(CW)) dut (
    .I_CLK (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    bus.cfg_div = d;
    bus.req     = r;
  endtask

  task automatic set_len(input int idx, input int val);
    bus.req_len[idx*CW +: CW] = CW'(val);
  endtask

  task automatic push_job(input logic [N-1:0] g, input int count, input int div, input bit with_done);
    tick_exp_t e;
    for (int a = 0; a < count; a++) begin
      e.grant = g;
      e.addr  = CW'(a);
      e.gap   = (a == 0) ? div : div + 1;
      exp_ticks.push_back(e);
    end
    if (with_done) exp_dones.push_back(g);
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant == '0 && n < budget);
    checkOutput("grant_wait", 32'(bus.grant != '0), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done == '0 && n < budget);
    checkOutput("done_wait", 32'(bus.done != '0), 32'd1);
  endtask

  // Retire scoreboard entries as ticks and done pulses appear; tick spacing is measured
  // from the cycle grant rose or from the previous tick.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_grant = '0;
    end else begin
      if (bus.grant != '0 && prev_grant == '0) ref_cyc = cyc;
      prev_grant = bus.grant;
      if (bus.tick) begin
        if (exp_ticks.size() == 0) begin
          checkOutput("tick_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_ticks.pop_front();
          checkOutput("tick_addr", 32'(bus.O_ADDR), 32'(mon_e.addr));
          checkOutput("tick_grant", 32'(bus.grant), 32'(mon_e.grant));
          checkOutput("tick_gap", cyc - ref_cyc, mon_e.gap);
        end
        ref_cyc = cyc;
      end
      if (bus.done != '0) begin
        if (exp_dones.size() == 0) begin
          checkOutput("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          mon_d = exp_dones.pop_front();
          checkOutput("done_owner", 32'(bus.done), 32'(mon_d));
          checkOutput("done_grant", 32'(bus.grant), 32'(mon_d));
          checkOutput("done_tick", 32'(bus.tick), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] run did not complete");
  end

  initial begin
    int n;
    int n_ticks;
    logic [N-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    bus.req     = '0;
    bus.cfg_div = '0;
    bus.req_len = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_tick", 32'(bus.tick), 32'd0);
    checkOutput("rst_addr", 32'(bus.O_ADDR), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single job, len 4, div 1");
    set_len(0, 4);
    push_job(4'b0001, 4, 1, 1'b1);
    applyStimulus(4'b0001, 8'd1);
    @(negedge clk);
    checkOutput("t1_grant", 32'(bus.grant), 32'h1);
    checkOutput("t1_busy", 32'(bus.busy), 32'd1);
    wait_done(100);
    bus.req = '0;
    @(negedge clk);
    checkOutput("t1_grant_off", 32'(bus.grant), 32'd0);
    checkOutput("t1_busy_off", 32'(bus.busy), 32'd0);

    $display("[TB] round robin over four requesters");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_len(i, 1);
    for (int k = 0; k < 5; k++) push_job(order[k], 1, 0, 1'b1);
    applyStimulus(4'b1111, 8'd0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(20);
      checkOutput("t2_order", 32'(bus.grant), 32'(order[k]));
      wait_done(20);
      if (k == 4) bus.req = '0;
    end
    @(negedge clk);
    checkOutput("t2_idle", 32'(bus.grant), 32'd0);

    $display("[TB] zero-length job");
    set_len(2, 0);
    exp_dones.push_back(4'b0100);
    applyStimulus(4'b0100, 8'd0);
    @(negedge clk);
    checkOutput("t3_grant", 32'(bus.grant), 32'h4);
    checkOutput("t3_done", 32'(bus.done), 32'h4);
    checkOutput("t3_tick", 32'(bus.tick), 32'd0);
    bus.req = '0;
    @(negedge clk);
    checkOutput("t3_grant_off", 32'(bus.grant), 32'd0);

    $display("[TB] abort after three ticks");
    set_len(1, 10);
    push_job(4'b0010, 3, 0, 1'b0);
    applyStimulus(4'b0010, 8'd0);
    wait_grant(10);
    checkOutput("t4_grant", 32'(bus.grant), 32'h2);
    n_ticks = bus.tick ? 1 : 0;
    n = 0;
    while (n_ticks < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.tick) n_ticks++;
    end
    checkOutput("t4_three_ticks", n_ticks, 3);
    bus.req = '0;
    @(negedge clk);
    checkOutput("t4_grant_off", 32'(bus.grant), 32'd0);
    checkOutput("t4_tick_off", 32'(bus.tick), 32'd0);
    checkOutput("t4_no_done", 32'(bus.done), 32'd0);
    checkOutput("t4_busy_off", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) set_len(i, 1);
    push_job(4'b0100, 1, 0, 1'b1);
    applyStimulus(4'b1111, 8'd0);
    wait_grant(10);
    checkOutput("t4_next_winner", 32'(bus.grant), 32'h4);
    wait_done(20);
    bus.req = '0;
    @(negedge clk);

    $display("[TB] async reset mid-job");
    set_len(0, 20);
    push_job(4'b0001, 6, 0, 1'b0);
    applyStimulus(4'b0001, 8'd0);
    wait_grant(10);
    n = 0;
    while (!(bus.tick && bus.O_ADDR == CW'(5)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_reach5", 32'(bus.O_ADDR), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_grant", 32'(bus.grant), 32'd0);
    checkOutput("t5_tick", 32'(bus.tick), 32'd0);
    checkOutput("t5_addr", 32'(bus.O_ADDR), 32'd0);
    checkOutput("t5_done", 32'(bus.done), 32'd0);
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_len(1, 1);
    set_len(3, 1);
    push_job(4'b0010, 1, 0, 1'b1);
    applyStimulus(4'b1010, 8'd0);
    wait_grant(10);
    checkOutput("t5_ptr_zero", 32'(bus.grant), 32'h2);
    wait_done(20);
    bus.req = '0;
    @(negedge clk);

    $display("[TB] divide ratio sampled only at grant");
    set_len(2, 3);
    push_job(4'b0100, 3, 3, 1'b1);
    applyStimulus(4'b0100, 8'd3);
    wait_grant(10);
    n = 0;
    while (!bus.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_first_tick", 32'(bus.tick), 32'd1);
    bus.cfg_div = 8'd0;
    wait_done(40);
    bus.req = '0;
    @(negedge clk);
    set_len(2, 2);
    push_job(4'b0100, 2, 0, 1'b1);
    applyStimulus(4'b0100, 8'd0);
    wait_grant(10);
    wait_done(20);
    bus.req = '0;

    repeat (3) @(negedge clk);
    checkOutput("ticks_left", exp_ticks.size(), 0);
    checkOutput("dones_left", exp_dones.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
